// File: rtl/elevator_pkg.sv
// elevator_pkg: shared types, direction constants and hall-button mask builder
package elevator_pkg;
  localparam int MAX_FLOORS = 64;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP_UP = 2'd1, SWEEP_DOWN = 2'd2} state_t;
  typedef enum logic [1:0] {LOWEST_GE, LOWEST_GT, HIGHEST_LE, HIGHEST_LT} pe_mode_t;
  function automatic logic [MAX_FLOORS-1:0] build_mask(input int num_floors, input logic dir);
    logic [MAX_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_FLOORS; i++)
      if (i < num_floors) m[i] = dir ? (i != num_floors - 1) : (i != 0);
    return m;
  endfunction
endpackage

// File: rtl/floor_priority_encoder.sv
// floor_priority_encoder: finds the lowest or highest set floor relative to a threshold
module floor_priority_encoder
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] vec,
  input  logic [FLOOR_W-1:0]    threshold,
  input  pe_mode_t              mode,
  output logic                  found,
  output logic [FLOOR_W-1:0]    index
);
  logic [NUM_FLOORS-1:0] qual;
  // keep only floors on the requested side of the threshold
  always_comb begin
    qual = '0;
    for (int i = 0; i < NUM_FLOORS; i++)
      qual[i] = vec[i] && (mode == LOWEST_GE  ? i >= int'(threshold) :
                           mode == LOWEST_GT  ? i >  int'(threshold) :
                           mode == HIGHEST_LE ? i <= int'(threshold) :
                                                i <  int'(threshold));
  end
  // scan from the far end so the last qualifying floor seen is the extreme one
  always_comb begin
    found = |qual;
    index = '0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (mode == LOWEST_GE || mode == LOWEST_GT) begin
        if (qual[NUM_FLOORS-1-i]) index = FLOOR_W'(NUM_FLOORS - 1 - i);
      end else if (qual[i]) index = FLOOR_W'(i);
  end
endmodule

// File: rtl/hall_call_scheduler.sv
// hall_call_scheduler: latches hall calls and publishes a SCAN-ordered registered target
module hall_call_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] up_req,
  input  logic [NUM_FLOORS-1:0] down_req,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  service_done,
  output logic [NUM_FLOORS-1:0] pending_up,
  output logic [NUM_FLOORS-1:0] pending_down,
  output logic                  target_valid,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  up_down_flag
);
  localparam logic [MAX_FLOORS-1:0] UP_MASK_FULL = build_mask(NUM_FLOORS, DIR_UP);
  localparam logic [MAX_FLOORS-1:0] DOWN_MASK_FULL = build_mask(NUM_FLOORS, DIR_DOWN);
  localparam logic [NUM_FLOORS-1:0] UP_MASK = UP_MASK_FULL[NUM_FLOORS-1:0];
  localparam logic [NUM_FLOORS-1:0] DOWN_MASK = DOWN_MASK_FULL[NUM_FLOORS-1:0];
  localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);
  localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);
  state_t state, state_nx;
  logic tv_nx, fl_nx;
  logic [FLOOR_W-1:0] tf_nx;
  logic up_ge_found, up_lo_found, dn_le_found, dn_hi_found;
  logic [FLOOR_W-1:0] up_ge_idx, up_lo_idx, dn_le_idx, dn_hi_idx;
  logic cur_ok, at_up, at_dn, up_above, dn_above, up_below, dn_below, any_above, any_below;
  logic hit;
  logic [NUM_FLOORS-1:0] clr_bit, clr_up, clr_dn;

  floor_priority_encoder #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_up_ge (
    .vec(pending_up), .threshold(current_floor), .mode(LOWEST_GE),
    .found(up_ge_found), .index(up_ge_idx));
  floor_priority_encoder #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_up_lo (
    .vec(pending_up), .threshold('0), .mode(LOWEST_GE),
    .found(up_lo_found), .index(up_lo_idx));
  floor_priority_encoder #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_dn_le (
    .vec(pending_down), .threshold(current_floor), .mode(HIGHEST_LE),
    .found(dn_le_found), .index(dn_le_idx));
  floor_priority_encoder #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_dn_hi (
    .vec(pending_down), .threshold(TOP), .mode(HIGHEST_LE),
    .found(dn_hi_found), .index(dn_hi_idx));

  assign cur_ok = int'(current_floor) < NUM_FLOORS;
  assign at_up = up_ge_found && up_ge_idx == current_floor;
  assign at_dn = dn_le_found && dn_le_idx == current_floor;
  assign up_above = up_ge_found && up_ge_idx != current_floor;
  assign dn_above = dn_hi_found && dn_hi_idx > current_floor;
  assign up_below = up_lo_found && up_lo_idx < current_floor;
  assign dn_below = dn_le_found && !at_dn;
  assign any_above = up_above || dn_above;
  assign any_below = up_below || dn_below;

  assign hit = service_done && target_valid && current_floor == target_floor;
  assign clr_bit = hit ? ONE << target_floor : '0;
  assign clr_up = (state == IDLE || up_down_flag == DIR_UP) ? clr_bit : '0;
  assign clr_dn = (state == IDLE || up_down_flag == DIR_DOWN) ? clr_bit : '0;

  // SCAN decision from the registered pending vectors; no target while the state changes
  always_comb begin
    state_nx = state;
    tv_nx = 1'b0;
    tf_nx = '0;
    fl_nx = DIR_DOWN;
    if (cur_ok)
      case (state)
        IDLE:
          if (at_up || at_dn) begin
            tv_nx = 1'b1;
            tf_nx = current_floor;
            fl_nx = at_up;
          end else if (any_above) state_nx = SWEEP_UP;
          else if (any_below) state_nx = SWEEP_DOWN;
        SWEEP_UP:
          if (up_ge_found) begin
            tv_nx = 1'b1;
            tf_nx = up_ge_idx;
            fl_nx = DIR_UP;
          end else if (dn_above) begin
            tv_nx = 1'b1;
            tf_nx = dn_hi_idx;
            fl_nx = DIR_DOWN;
          end else state_nx = (dn_le_found || up_below) ? SWEEP_DOWN : IDLE;
        SWEEP_DOWN:
          if (dn_le_found) begin
            tv_nx = 1'b1;
            tf_nx = dn_le_idx;
            fl_nx = DIR_DOWN;
          end else if (up_below) begin
            tv_nx = 1'b1;
            tf_nx = up_lo_idx;
            fl_nx = DIR_UP;
          end else state_nx = (up_ge_found || dn_above) ? SWEEP_UP : IDLE;
        default: state_nx = IDLE;
      endcase
  end

  // call latches (new presses beat same-cycle clears), FSM and registered target
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending_up <= '0;
      pending_down <= '0;
      state <= IDLE;
      target_valid <= 1'b0;
      target_floor <= '0;
      up_down_flag <= DIR_DOWN;
    end else begin
      pending_up <= (pending_up & ~clr_up) | (up_req & UP_MASK);
      pending_down <= (pending_down & ~clr_dn) | (down_req & DOWN_MASK);
      state <= state_nx;
      target_valid <= tv_nx;
      target_floor <= tf_nx;
      up_down_flag <= fl_nx;
    end
endmodule

// File: tb/tb_hall_call_scheduler.sv
// tb_hall_call_scheduler: directed scenarios plus random traffic against a floor-scan model
module tb_hall_call_scheduler;
  localparam int NF = 4;
  localparam int S_IDLE = 0, S_UP = 1, S_DN = 2;
  logic clk = 1'b0, rst_n = 1'b0, service_done = 1'b0;
  logic [3:0] up_req = '0, down_req = '0, pending_up, pending_down;
  logic [1:0] current_floor = '0, target_floor;
  logic target_valid, up_down_flag;
  int checks = 0, errors = 0;
  bit m_pu[NF], m_pd[NF], m_tv, m_fl;
  int m_st, m_tf;

  hall_call_scheduler #(.NUM_FLOORS(NF)) dut (
    .clk(clk), .rst_n(rst_n), .up_req(up_req), .down_req(down_req),
    .current_floor(current_floor), .service_done(service_done),
    .pending_up(pending_up), .pending_down(pending_down), .target_valid(target_valid),
    .target_floor(target_floor), .up_down_flag(up_down_flag));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    up_req = '0;
    down_req = '0;
    service_done = 1'b0;
    current_floor = '0;
    #3;
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic model_step(input logic [3:0] ur, input logic [3:0] dr, input int cur, input bit sd);
    bit pu[NF], pd[NF], tv, fl, above, below;
    int st, tf, f;
    pu = m_pu; pd = m_pd; st = m_st; tv = 0; tf = 0; fl = 0; above = 0; below = 0; f = -1;
    for (int i = 0; i < NF; i++) begin
      if (i > cur && (m_pu[i] || m_pd[i])) above = 1;
      if (i < cur && (m_pu[i] || m_pd[i])) below = 1;
    end
    if (st == S_IDLE) begin
      if (m_pu[cur] || m_pd[cur]) begin tv = 1; tf = cur; fl = m_pu[cur]; end
      else if (above) st = S_UP;
      else if (below) st = S_DN;
    end else if (st == S_UP) begin
      for (int i = NF - 1; i >= cur; i--) if (m_pu[i]) f = i;
      if (f >= 0) begin tv = 1; tf = f; fl = 1; end
      else begin
        for (int i = cur + 1; i < NF; i++) if (m_pd[i]) f = i;
        if (f >= 0) begin tv = 1; tf = f; fl = 0; end
        else st = (m_pd[cur] || below) ? S_DN : S_IDLE;
      end
    end else begin
      for (int i = 0; i <= cur; i++) if (m_pd[i]) f = i;
      if (f >= 0) begin tv = 1; tf = f; fl = 0; end
      else begin
        for (int i = cur - 1; i >= 0; i--) if (m_pu[i]) f = i;
        if (f >= 0) begin tv = 1; tf = f; fl = 1; end
        else st = (above || m_pu[cur]) ? S_UP : S_IDLE;
      end
    end
    if (sd && m_tv && cur == m_tf) begin
      if (m_st == S_IDLE || m_fl) pu[m_tf] = 0;
      if (m_st == S_IDLE || !m_fl) pd[m_tf] = 0;
    end
    for (int i = 0; i < NF; i++) begin
      if (ur[i] && i != NF - 1) pu[i] = 1;
      if (dr[i] && i != 0) pd[i] = 1;
    end
    m_pu = pu; m_pd = pd; m_st = st; m_tv = tv; m_tf = tf; m_fl = fl;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; up_req = 4'b0001; down_req = '0; current_floor = '0; service_done = 1'b0;
    repeat (2) begin
      tick;
      checks++; if ({pending_up, pending_down, target_valid, target_floor, up_down_flag} !== 13'd0) begin errors++; $display("FAIL reset_hold: got %h exp 0", {pending_up, pending_down, target_valid, target_floor, up_down_flag}); end
    end
    #2 rst_n = 1'b1;
    tick;
    checks++; if (pending_up !== 4'b0001) begin errors++; $display("FAIL reset_pend: got %b exp 0001", pending_up); end
    checks++; if (target_valid !== 1'b0) begin errors++; $display("FAIL reset_tv1: got %b exp 0", target_valid); end
    tick;
    checks++; if ({target_valid, target_floor, up_down_flag} !== 4'b1001) begin errors++; $display("FAIL reset_target: got %b exp 1001", {target_valid, target_floor, up_down_flag}); end
    up_req = '0; service_done = 1'b1;
    tick;
    service_done = 1'b0;
    checks++; if (pending_up !== 4'b0000) begin errors++; $display("FAIL reset_clear: got %b exp 0000", pending_up); end
    tick;
    checks++; if (target_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b exp 0", target_valid); end
  endtask

  task automatic test_illegal;
    do_reset;
    up_req = 4'b1000; down_req = 4'b0001;
    repeat (4) begin
      tick;
      checks++; if ({pending_up, pending_down, target_valid} !== 9'd0) begin errors++; $display("FAIL illegal: got %h exp 0", {pending_up, pending_down, target_valid}); end
    end
    up_req = '0; down_req = '0;
  endtask

  task automatic test_sweep;
    int ftab[3] = '{1, 2, 3};
    bit dtab[3] = '{1, 1, 0};
    do_reset;
    up_req = 4'b0110; down_req = 4'b1000;
    tick;
    up_req = '0; down_req = '0;
    tick;
    tick;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({target_valid, target_floor, up_down_flag} !== {1'b1, 2'(ftab[i]), dtab[i]}) begin errors++; $display("FAIL sweep_%0d: got %b exp %b", i, {target_valid, target_floor, up_down_flag}, {1'b1, 2'(ftab[i]), dtab[i]}); end
      current_floor = 2'(ftab[i]); service_done = 1'b1;
      tick;
      service_done = 1'b0;
      tick;
    end
    checks++; if ({pending_up, pending_down, target_valid} !== 9'd0) begin errors++; $display("FAIL sweep_end: got %h exp 0", {pending_up, pending_down, target_valid}); end
  endtask

  task automatic test_reversal;
    do_reset;
    up_req = 4'b0100;
    tick;
    up_req = '0;
    tick;
    tick;
    checks++; if ({target_valid, target_floor, up_down_flag} !== 4'b1101) begin errors++; $display("FAIL rev_first: got %b exp 1101", {target_valid, target_floor, up_down_flag}); end
    current_floor = 2'd2; service_done = 1'b1; down_req = 4'b0010;
    tick;
    service_done = 1'b0; down_req = '0;
    checks++; if ({pending_up, pending_down} !== 8'b0000_0010) begin errors++; $display("FAIL rev_pend: got %b exp 00000010", {pending_up, pending_down}); end
    tick;
    checks++; if (target_valid !== 1'b0) begin errors++; $display("FAIL rev_turn: got %b exp 0", target_valid); end
    tick;
    checks++; if ({target_valid, target_floor, up_down_flag} !== 4'b1010) begin errors++; $display("FAIL rev_target: got %b exp 1010", {target_valid, target_floor, up_down_flag}); end
  endtask

  task automatic test_collision;
    do_reset;
    current_floor = 2'd1; up_req = 4'b0010;
    tick;
    up_req = '0;
    tick;
    checks++; if ({target_valid, target_floor, up_down_flag} !== 4'b1011) begin errors++; $display("FAIL coll_target: got %b exp 1011", {target_valid, target_floor, up_down_flag}); end
    service_done = 1'b1; up_req = 4'b0010;
    tick;
    up_req = '0;
    checks++; if (pending_up !== 4'b0010) begin errors++; $display("FAIL coll_keep: got %b exp 0010", pending_up); end
    tick;
    service_done = 1'b0;
    checks++; if (pending_up !== 4'b0000) begin errors++; $display("FAIL coll_clear: got %b exp 0000", pending_up); end
  endtask

  task automatic test_async_reset;
    do_reset;
    up_req = 4'b0110; down_req = 4'b1000;
    tick;
    up_req = '0; down_req = '0;
    tick;
    tick;
    checks++; if ({target_valid, target_floor, up_down_flag} !== 4'b1011) begin errors++; $display("FAIL async_pre: got %b exp 1011", {target_valid, target_floor, up_down_flag}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({pending_up, pending_down, target_valid, target_floor, up_down_flag} !== 13'd0) begin errors++; $display("FAIL async_zero: got %h exp 0", {pending_up, pending_down, target_valid, target_floor, up_down_flag}); end
    #2 rst_n = 1'b1;
    up_req = 4'b0100;
    tick;
    up_req = '0;
    tick;
    checks++; if (target_valid !== 1'b0) begin errors++; $display("FAIL async_idle: got %b exp 0", target_valid); end
    tick;
    checks++; if ({target_valid, target_floor, up_down_flag} !== 4'b1101) begin errors++; $display("FAIL async_after: got %b exp 1101", {target_valid, target_floor, up_down_flag}); end
  endtask

  task automatic test_random;
    do_reset;
    for (int i = 0; i < NF; i++) begin m_pu[i] = 0; m_pd[i] = 0; end
    m_st = S_IDLE; m_tv = 0; m_tf = 0; m_fl = 0;
    for (int c = 0; c < 1500; c++) begin
      logic [3:0] ur, dr, epu, epd;
      int cur;
      bit sd;
      for (int i = 0; i < NF; i++) begin
        ur[i] = ($urandom_range(7) == 0);
        dr[i] = ($urandom_range(7) == 0);
      end
      cur = (m_tv && $urandom_range(1) == 1) ? m_tf : int'($urandom_range(NF - 1));
      sd = ($urandom_range(2) == 0);
      up_req = ur; down_req = dr; current_floor = 2'(cur); service_done = sd;
      model_step(ur, dr, cur, sd);
      tick;
      for (int i = 0; i < NF; i++) begin epu[i] = m_pu[i]; epd[i] = m_pd[i]; end
      checks++; if (pending_up !== epu) begin errors++; $display("FAIL rnd_pu c=%0d: got %b exp %b", c, pending_up, epu); end
      checks++; if (pending_down !== epd) begin errors++; $display("FAIL rnd_pd c=%0d: got %b exp %b", c, pending_down, epd); end
      checks++; if (target_valid !== m_tv) begin errors++; $display("FAIL rnd_tv c=%0d: got %b exp %b", c, target_valid, m_tv); end
      checks++; if (target_floor !== 2'(m_tf)) begin errors++; $display("FAIL rnd_tf c=%0d: got %0d exp %0d", c, target_floor, m_tf); end
      checks++; if (up_down_flag !== m_fl) begin errors++; $display("FAIL rnd_fl c=%0d: got %b exp %b", c, up_down_flag, m_fl); end
    end
    up_req = '0; down_req = '0; service_done = 1'b0;
  endtask

  initial begin
    test_reset;
    test_illegal;
    test_sweep;
    test_reversal;
    test_collision;
    test_async_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
